sobel_edge_stream: RTL and testbench

- Streaming 3x3 Sobel edge detector. It consumes an 8-bit grayscale pixel stream in raster order and emits a binary edge map with coordinates.
- Its output drives the 3-bit pixel_rgb of the VGA display path, either via the frame buffer or directly.
- It sits directly upstream of the VGA output stage. Tagged coordinates let the consumer write to the matching address.

---
 rtl/sobel_pkg.sv | 28 ++
 rtl/sobel_line_buffer.sv | 29 ++
 rtl/sobel_edge_stream.sv | 174 +++++++++++++++++
 tb/tb_sobel_edge_stream.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, default geometry/threshold, output colours and
// small gradient helpers for the streaming Sobel edge detector.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int COORD_W = 10;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int THRESH_DEF = 128;

  localparam logic [2:0] EDGE_RGB = 3'b111;
  localparam logic [2:0] BG_RGB   = 3'b000;

  typedef logic signed [GRAD_W-1:0] grad_t;

  // Zero-extend a pixel into the signed gradient width.
  function automatic grad_t widen(input logic [PIX_W-1:0] p);
    return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // |g|; the gradient range (+/-1020) never reaches the most negative code.
  function automatic logic [GRAD_W-1:0] abs_grad(input grad_t g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: single-clock simple dual-port RAM, DEPTH x PIX_W.
// 1-cycle synchronous read; a read and write to the same address in one
// cycle returns the old contents. Contents are not reset.
//   clk              clock
//   wr_en/addr/data  write port
//   rd_addr          read address, sampled every cycle
//   rd_data          registered read data
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge detector, raster-order 8-bit
// grayscale in, binary edge map with centre coordinates out. Latency 3 clk.
//   clk, reset     pixel clock, async active-high reset
//   in_valid       pixel accepted this cycle (no backpressure)
//   in_sof         start of frame, forces current pixel to (0,0)
//   in_pix         grayscale sample
//   out_valid      result valid
//   out_edge       edge flag for (out_x,out_y)
//   out_rgb        EDGE_RGB / BG_RGB
//   out_x, out_y   centre coordinates
//   out_mag        min(|Gx|+|Gy|,255), only with SOBEL_MAG_OUT_EN defined
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_valid,
  output logic               out_edge,
  output logic [2:0]         out_rgb,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
`ifdef SOBEL_MAG_OUT_EN
  ,
  output logic [7:0]         out_mag
`endif
);

  localparam int LB_AW = $clog2(IMG_W);

  logic [COORD_W-1:0] col, row, cur_col, cur_row;
  logic [PIX_W-1:0]   tap1, tap2;

  // Input register stage; the RAM taps arrive alongside it one cycle later.
  logic               s0_valid, s0_emit;
  logic [PIX_W-1:0]   s0_pix;
  logic [COORD_W-1:0] s0_x, s0_y;
  logic [LB_AW-1:0]   s0_col;

  logic [PIX_W-1:0]   win [3][3];  // [row][col], row 0 = oldest line, col 2 = newest
  logic               s1_valid;
  logic [COORD_W-1:0] s1_x, s1_y;

  grad_t              gx_c, gy_c, gx, gy;
  logic               s2_valid, s2_border;
  logic [COORD_W-1:0] s2_x, s2_y;

  logic [GRAD_W-1:0]  mag_c;

  always_comb begin
    cur_col = (in_valid && in_sof) ? '0 : col;
    cur_row = (in_valid && in_sof) ? '0 : row;
  end

  // Row r-1 buffer: written with the incoming pixel.
  sobel_line_buffer #(.DEPTH(IMG_W), .AW(LB_AW)) u_lb1 (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_addr (cur_col[LB_AW-1:0]),
    .wr_data (in_pix),
    .rd_addr (cur_col[LB_AW-1:0]),
    .rd_data (tap1)
  );

  // Row r-2 buffer: the displaced r-1 value is only known after the read,
  // so its write lands one cycle later at the same column.
  sobel_line_buffer #(.DEPTH(IMG_W), .AW(LB_AW)) u_lb2 (
    .clk     (clk),
    .wr_en   (s0_valid),
    .wr_addr (s0_col),
    .wr_data (tap1),
    .rd_addr (cur_col[LB_AW-1:0]),
    .rd_data (tap2)
  );

  always_comb begin
    gx_c = (widen(win[0][2]) + (widen(win[1][2]) <<< 1) + widen(win[2][2]))
         - (widen(win[0][0]) + (widen(win[1][0]) <<< 1) + widen(win[2][0]));
    gy_c = (widen(win[2][0]) + (widen(win[2][1]) <<< 1) + widen(win[2][2]))
         - (widen(win[0][0]) + (widen(win[0][1]) <<< 1) + widen(win[0][2]));
    mag_c = abs_grad(gx) + abs_grad(gy);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      s0_valid  <= 1'b0;
      s0_emit   <= 1'b0;
      s0_pix    <= '0;
      s0_x      <= '0;
      s0_y      <= '0;
      s0_col    <= '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      gx        <= '0;
      gy        <= '0;
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      out_valid <= 1'b0;
      out_edge  <= 1'b0;
      out_rgb   <= BG_RGB;
      out_x     <= '0;
      out_y     <= '0;
`ifdef SOBEL_MAG_OUT_EN
      out_mag   <= '0;
`endif
    end else begin
      // Counters and input register
      s0_valid <= in_valid;
      if (in_valid) begin
        if (cur_col == COORD_W'(IMG_W - 1)) begin
          col <= '0;
          row <= (cur_row == COORD_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
        s0_pix  <= in_pix;
        s0_emit <= (cur_col != '0) && (cur_row != '0);
        s0_x    <= cur_col - 1'b1;
        s0_y    <= cur_row - 1'b1;
        s0_col  <= cur_col[LB_AW-1:0];
      end

      // Window shift, only on accepted pixels
      s1_valid <= s0_valid && s0_emit;
      if (s0_valid) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= tap2;
        win[1][2] <= tap1;
        win[2][2] <= s0_pix;
        s1_x      <= s0_x;
        s1_y      <= s0_y;
      end

      // Gradient
      s2_valid  <= s1_valid;
      gx        <= gx_c;
      gy        <= gy_c;
      s2_border <= (s1_x == '0) || (s1_y == '0);
      s2_x      <= s1_x;
      s2_y      <= s1_y;

      // Magnitude, threshold, output register
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_edge <= !s2_border && (mag_c >= GRAD_W'(THRESH));
        out_rgb  <= (!s2_border && (mag_c >= GRAD_W'(THRESH))) ? EDGE_RGB : BG_RGB;
        out_x    <= s2_x;
        out_y    <= s2_y;
`ifdef SOBEL_MAG_OUT_EN
        out_mag  <= (mag_c > GRAD_W'(255)) ? 8'hFF : mag_c[7:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: directed checks of sobel_edge_stream on an 8x6 image.
// Expected results come from the driven image (column step at x=4) and the
// hand-derived Sobel response: only centres x=3,4 see the step, |Gx|=4*step.
module tb_sobel_edge_stream;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pix = '0;
  logic       out_valid, out_edge;
  logic [2:0] out_rgb;
  logic [9:0] out_x, out_y;
`ifdef SOBEL_MAG_OUT_EN
  logic [7:0] out_mag;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int x;
    int y;
    int e;
    int rgb;
    int cyc;
  } res_t;

  res_t exp_q[$];
  res_t cap_q[$];
  res_t cap_r;

  sobel_edge_stream #(.IMG_W(W), .IMG_H(H), .THRESH(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_edge  (out_edge),
    .out_rgb   (out_rgb),
    .out_x     (out_x),
    .out_y     (out_y)
`ifdef SOBEL_MAG_OUT_EN
    ,
    .out_mag   (out_mag)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result with the index of the clock edge that produced it.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_r.x   = int'(out_x);
      cap_r.y   = int'(out_y);
      cap_r.e   = int'(out_edge);
      cap_r.rgb = int'(out_rgb);
      cap_r.cyc = cyc;
      cap_q.push_back(cap_r);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_edge(input int lo, input int hi, input int cx, input int cy);
    int d;
    d = (hi > lo) ? hi - lo : lo - hi;
    if (cx == 0 || cy == 0) return 0;
    if ((cx == 3 || cx == 4) && 4 * d >= 128) return 1;
    return 0;
  endfunction

  task automatic drive(input int x, input int y, input int lo, input int hi, input bit sof);
    res_t r;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = 8'((x < 4) ? lo : hi);
    if (x >= 1 && y >= 1) begin
      r.x   = x - 1;
      r.y   = y - 1;
      r.e   = exp_edge(lo, hi, x - 1, y - 1);
      r.rgb = r.e ? 7 : 0;
      r.cyc = cyc + 1;
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Send the first n pixels of a frame (cols 0-3 = lo, 4-7 = hi).
  task automatic frame(input int lo, input int hi, input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      drive(i % W, i / W, lo, hi, i == 0);
      if (gaps) idle(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic check_sb(input string tag, input int n);
    int m;
    chk({tag, ".count"}, cap_q.size(), n);
    m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s[%0d].x", tag, i), cap_q[i].x, exp_q[i].x);
      chk($sformatf("%s[%0d].y", tag, i), cap_q[i].y, exp_q[i].y);
      chk($sformatf("%s[%0d].edge", tag, i), cap_q[i].e, exp_q[i].e);
      chk($sformatf("%s[%0d].rgb", tag, i), cap_q[i].rgb, exp_q[i].rgb);
      chk($sformatf("%s[%0d].latency", tag, i), cap_q[i].cyc - exp_q[i].cyc, 3);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_edge", int'(out_edge), 0);
    chk("rst.out_rgb", int'(out_rgb), 0);
    chk("rst.out_x", int'(out_x), 0);
    chk("rst.out_y", int'(out_y), 0);
    @(negedge clk);
    reset = 1'b0;

    // Flat image: no edges, 35 results in raster order
    frame(100, 100, 1'b0, W * H);
    idle(6);
    check_sb("flat", 35);

    // Full-scale step: mag 1020 at x=3,4
    frame(0, 255, 1'b0, W * H);
    idle(6);
    check_sb("step255", 35);

    // Threshold boundary: 4*32=128 is an edge, 4*31=124 is not
    frame(0, 32, 1'b0, W * H);
    idle(6);
    check_sb("step32", 35);
    frame(0, 31, 1'b0, W * H);
    idle(6);
    check_sb("step31", 35);

    // Random idle gaps: same sequence, latency still 3
    frame(0, 255, 1'b1, W * H);
    idle(6);
    check_sb("gaps", 35);

    // Latency of the pixel at (2,2), isolated by idle cycles
    frame(0, 255, 1'b0, 2 * W + 2);
    idle(6);
    check_sb("lat_pre", 8);
    drive(2, 2, 0, 255, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("lat.gap%0d.out_valid", k), int'(out_valid), 0);
    end
    @(negedge clk);
    chk("lat.out_valid", int'(out_valid), 1);
    chk("lat.out_x", int'(out_x), 1);
    chk("lat.out_y", int'(out_y), 1);
    chk("lat.out_edge", int'(out_edge), 0);
    idle(4);
    check_sb("lat", 1);

    // Mid-frame reset right after pixel (5,3) is accepted
    frame(0, 255, 1'b0, 3 * W + 6);
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst.out_valid", int'(out_valid), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.out_edge", int'(out_edge), 0);
    chk("midrst.out_rgb", int'(out_rgb), 0);
    chk("midrst.out_x", int'(out_x), 0);
    chk("midrst.out_y", int'(out_y), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    exp_q.delete();
    frame(0, 255, 1'b0, W * H);
    idle(6);
    check_sb("postrst", 35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
